// File: rtl/spi_burst_sequencer_pkg.sv
// Shared SPI definitions: sequencer and byte-master state types plus default timing.
package spi_burst_sequencer_pkg;

    localparam int DEF_MAX_BYTES = 16;
    localparam int DEF_CS_SETUP  = 8;
    localparam int DEF_CS_HOLD   = 8;
    localparam int TIMER_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WAIT_FALL,
        S_HOLD,
        S_DONE
    } SeqState;

    typedef enum logic [1:0] {
        M_IDLE,
        M_LOAD,
        M_SHIFT,
        M_COMPLETE
    } MasterState;

endpackage

// File: rtl/spi_burst_sequencer_if.sv
// Host-side buffer/control bus and byte-master handshake of the burst sequencer.
interface spi_burst_sequencer_if;

    logic       start;
    logic [4:0] byte_count;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       start_err;
    logic       cs_n;
    logic       spi_tx_en;
    logic [7:0] spi_tx_byte;
    logic       spi_complete;
    logic [7:0] spi_rx_byte;

    modport slave (
        input  start, byte_count, wr_en, wr_data, rd_addr, spi_complete, spi_rx_byte,
        output rd_data, busy, done, start_err, cs_n, spi_tx_en, spi_tx_byte
    );

    modport master (
        output start, byte_count, wr_en, wr_data, rd_addr, spi_complete, spi_rx_byte,
        input  rd_data, busy, done, start_err, cs_n, spi_tx_en, spi_tx_byte
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses taken from the second stage.
module spi_sync_edge (
    input  logic sysClk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge sysClk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
    assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/spi_burst_sequencer.sv
// Runs a chip-select-framed burst of bytes through an external SPI byte master,
// sending from an inline TX buffer and capturing replies into an inline RX buffer.
module spi_burst_sequencer
    import spi_burst_sequencer_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int CS_SETUP  = DEF_CS_SETUP,
    parameter int CS_HOLD   = DEF_CS_HOLD
) (
    input  logic                 sysClk,
    input  logic                 reset,
    spi_burst_sequencer_if.slave bus
);

    localparam int                 AW         = $clog2(MAX_BYTES);
    localparam logic [4:0]         MAX_CNT    = 5'(MAX_BYTES);
    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(CS_SETUP - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(CS_HOLD - 1);

    logic [7:0] tx_mem [MAX_BYTES];
    logic [7:0] rx_mem [MAX_BYTES];

    SeqState            state;
    SeqState            state_nx;
    logic [4:0]         wptr;
    logic [4:0]         idx;
    logic [4:0]         idx_inc;
    logic [4:0]         count;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         rx_p0;
    logic [7:0]         rx_p1;
    logic               cmpl_rise;
    logic               cmpl_fall;
    logic               accept;
    logic               wr_ok;
    logic               capture;
    logic [AW-1:0]      tx_sel;

    logic       cs_n;
    logic       tx_en;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       start_err;

    spi_sync_edge u_cmpl_sync (
        .sysClk (sysClk),
        .reset  (reset),
        .din    (bus.spi_complete),
        .rise   (cmpl_rise),
        .fall   (cmpl_fall)
    );

    assign idx_inc = idx + 5'd1;
    assign accept  = (state == S_IDLE) && bus.start && (bus.byte_count != 5'd0)
                     && (bus.byte_count <= MAX_CNT) && (bus.byte_count <= wptr);
    assign wr_ok   = (state == S_IDLE) && bus.wr_en && (wptr < MAX_CNT);
    assign capture = (state == S_WAIT_FALL) && cmpl_fall;

    // tx_sel picks the byte to present on the cycle XFER is entered
    always_comb begin
        state_nx = state;
        tx_sel   = idx[AW-1:0];
        case (state)
            S_IDLE:      if (accept) state_nx = S_SETUP;
            S_SETUP:     if (timer == '0) state_nx = S_XFER;
            S_XFER:      if (cmpl_rise) state_nx = S_WAIT_FALL;
            S_WAIT_FALL: begin
                if (cmpl_fall) begin
                    if (idx_inc < count) begin
                        state_nx = S_XFER;
                        tx_sel   = idx_inc[AW-1:0];
                    end else begin
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD:      if (timer == '0) state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Outputs are registered from the next state so the SPI-facing lines never glitch
    always_ff @(posedge sysClk) begin
        if (reset) begin
            wptr      <= '0;
            idx       <= '0;
            count     <= '0;
            timer     <= '0;
            rx_p0     <= '0;
            rx_p1     <= '0;
            cs_n      <= 1'b1;
            tx_en     <= 1'b1;
            tx_byte   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            rx_p0 <= bus.spi_rx_byte;
            rx_p1 <= rx_p0;

            if (accept)
                timer <= SETUP_LOAD;
            else if (state_nx == S_HOLD && state != S_HOLD)
                timer <= HOLD_LOAD;
            else if (timer != '0)
                timer <= timer - 1'b1;

            if (accept) begin
                count <= bus.byte_count;
                idx   <= '0;
            end else if (capture) begin
                idx <= idx_inc;
            end

            if (state == S_DONE) wptr <= '0;
            else if (wr_ok)      wptr <= wptr + 5'd1;

            if (state_nx == S_XFER && state != S_XFER)
                tx_byte <= tx_mem[tx_sel];

            cs_n      <= (state_nx == S_IDLE) || (state_nx == S_DONE);
            busy      <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            tx_en     <= (state_nx != S_XFER);
            done      <= (state_nx == S_DONE);
            start_err <= bus.start && !accept;
        end
    end

    always_ff @(posedge sysClk) begin
        if (wr_ok)   tx_mem[wptr[AW-1:0]] <= bus.wr_data;
        if (capture) rx_mem[idx[AW-1:0]]  <= rx_p1;
    end

    assign bus.rd_data     = rx_mem[bus.rd_addr[AW-1:0]];
    assign bus.cs_n        = cs_n;
    assign bus.spi_tx_en   = tx_en;
    assign bus.spi_tx_byte = tx_byte;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.start_err   = start_err;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer with an inverting-echo byte-master model.
module tb_spi_burst_sequencer;

    localparam int CS_SETUP = 8;
    localparam int CS_HOLD  = 8;

    logic sysClk;
    logic reset;
    spi_burst_sequencer_if bus ();

    spi_burst_sequencer #(
        .MAX_BYTES (16),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD)
    ) dut (
        .sysClk (sysClk),
        .reset  (reset),
        .bus    (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         serr_cnt = 0;
    int         cs_hi_cnt = 0;
    int         xfer_cnt = 0;
    bit         in_burst = 0;

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge sysClk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.start_err === 1'b1) serr_cnt++;
        if (in_burst && bus.cs_n !== 1'b0 && bus.done !== 1'b1) cs_hi_cnt++;
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    // Byte master model: answers each enabled byte with its bitwise inverse
    initial begin
        bus.spi_complete = 1'b0;
        bus.spi_rx_byte  = 8'h00;
        forever begin
            tick();
            if (bus.spi_tx_en === 1'b0) begin
                repeat (3) tick();
                bus.spi_rx_byte  = ~bus.spi_tx_byte;
                bus.spi_complete = 1'b1;
                for (int i = 0; i < 50 && bus.spi_tx_en !== 1'b1; i++) tick();
                repeat (2) tick();
                bus.spi_complete = 1'b0;
                xfer_cnt++;
            end
        end
    end

    task automatic wr_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        bus.byte_count = n;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysClk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        in_burst = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.byte_count = '0; bus.wr_en = 1'b0;
        bus.wr_data = '0; bus.rd_addr = '0;
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", bus.cs_n); end
        checks++; if (bus.spi_tx_en !== 1'b1) begin errors++; $display("FAIL reset_tx_en got %b want 1", bus.spi_tx_en); end
        checks++; if (bus.spi_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", bus.spi_tx_byte); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got %b want 0", bus.start_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d0, c0;
        bit ok;
        logic [7:0] e;
        d0 = done_cnt; c0 = cs_hi_cnt;
        wr_byte(8'hA5); exp_q.push_back(8'h5A);
        wr_byte(8'h3C); exp_q.push_back(8'hC3);
        pulse_start(5'd2);
        in_burst = 1'b1;
        checks++; if (bus.cs_n !== 1'b0) begin errors++; $display("FAIL basic_cs_fall got %b want 0", bus.cs_n); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        repeat (CS_SETUP - 1) tick();
        checks++; if (bus.spi_tx_en !== 1'b1) begin errors++; $display("FAIL basic_tx_en_early got %b want 1", bus.spi_tx_en); end
        tick();
        checks++; if (bus.spi_tx_en !== 1'b0) begin errors++; $display("FAIL basic_tx_en_latency got %b want 0", bus.spi_tx_en); end
        checks++; if (bus.spi_tx_byte !== 8'hA5) begin errors++; $display("FAIL basic_tx_byte got %h want a5", bus.spi_tx_byte); end
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
        tick(); tick();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (cs_hi_cnt != c0) begin errors++; $display("FAIL basic_cs_gap got %0d want 0", cs_hi_cnt - c0); end
        checks++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin errors++; $display("FAIL basic_idle got busy=%b cs_n=%b want 0/1", bus.busy, bus.cs_n); end
        for (int i = 0; i < 2; i++) begin
            bus.rd_addr = 4'(i);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL basic_rx[%0d] got %h want %h", i, bus.rd_data, e); end
        end
    endtask

    task automatic test_short_load_err();
        int s0;
        s0 = serr_cnt;
        wr_byte(8'h96); exp_q.push_back(8'h69);
        pulse_start(5'd2);
        checks++; if (bus.start_err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", bus.start_err); end
        checks++; if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL short_idle got cs_n=%b busy=%b want 1/0", bus.cs_n, bus.busy); end
        tick();
        checks++; if (serr_cnt - s0 != 1 || bus.start_err !== 1'b0) begin errors++; $display("FAIL short_err_width got %0d cycles want 1", serr_cnt - s0); end
    endtask

    task automatic test_zero_count();
        int d0;
        bit ok;
        logic [7:0] e;
        pulse_start(5'd0);
        checks++; if (bus.start_err !== 1'b1) begin errors++; $display("FAIL zero_err got %b want 1", bus.start_err); end
        tick();
        checks++; if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_idle got cs_n=%b busy=%b want 1/0", bus.cs_n, bus.busy); end
        d0 = done_cnt;
        pulse_start(5'd1);
        in_burst = 1'b1;
        checks++; if (bus.start_err !== 1'b0 || bus.cs_n !== 1'b0) begin errors++; $display("FAIL zero_followup_accept got err=%b cs_n=%b want 0/0", bus.start_err, bus.cs_n); end
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout got 0 want 1"); end
        tick(); tick();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt - d0); end
        bus.rd_addr = 4'd0;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL zero_rx0 got %h want %h", bus.rd_data, e); end
    endtask

    task automatic test_start_during_burst();
        int d0, s0, x0, c0;
        bit ok;
        logic [7:0] e;
        wr_byte(8'h11); exp_q.push_back(8'hEE);
        wr_byte(8'h22); exp_q.push_back(8'hDD);
        wr_byte(8'h33); exp_q.push_back(8'hCC);
        d0 = done_cnt; s0 = serr_cnt; x0 = xfer_cnt; c0 = cs_hi_cnt;
        pulse_start(5'd3);
        in_burst = 1'b1;
        repeat (20) tick();
        pulse_start(5'd1);
        checks++; if (bus.start_err !== 1'b1) begin errors++; $display("FAIL busy_start_err got %b want 1", bus.start_err); end
        checks++; if (bus.busy !== 1'b1 || bus.cs_n !== 1'b0) begin errors++; $display("FAIL busy_undisturbed got busy=%b cs_n=%b want 1/0", bus.busy, bus.cs_n); end
        wait_done(1500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout got 0 want 1"); end
        tick(); tick();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (serr_cnt - s0 != 1) begin errors++; $display("FAIL busy_err_count got %0d want 1", serr_cnt - s0); end
        checks++; if (xfer_cnt - x0 != 3) begin errors++; $display("FAIL busy_byte_count got %0d want 3", xfer_cnt - x0); end
        checks++; if (cs_hi_cnt != c0) begin errors++; $display("FAIL busy_cs_gap got %0d want 0", cs_hi_cnt - c0); end
        for (int i = 0; i < 3; i++) begin
            bus.rd_addr = 4'(i);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL busy_rx[%0d] got %h want %h", i, bus.rd_data, e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int d0, x0;
        bit found;
        for (int i = 0; i < 4; i++) wr_byte(8'(8'h40 + i));
        d0 = done_cnt; x0 = xfer_cnt;
        pulse_start(5'd4);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (xfer_cnt - x0 == 2 && bus.spi_tx_en === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_byte3_timeout got 0 want 1"); end
        reset = 1'b1;
        tick();
        checks++; if (bus.cs_n !== 1'b1 || bus.spi_tx_en !== 1'b1) begin errors++; $display("FAIL rstmid_lines got cs_n=%b tx_en=%b want 1/1", bus.cs_n, bus.spi_tx_en); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        reset = 1'b0;
        repeat (60) tick();
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", done_cnt - d0); end
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_after got %b want 1", bus.cs_n); end
    endtask

    task automatic test_full_16();
        int d0, x0, c0;
        bit ok;
        logic [7:0] v, e;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            wr_byte(v);
            exp_q.push_back(~v);
        end
        wr_byte(8'hFF);
        d0 = done_cnt; x0 = xfer_cnt; c0 = cs_hi_cnt;
        pulse_start(5'd16);
        in_burst = 1'b1;
        checks++; if (bus.start_err !== 1'b0 || bus.cs_n !== 1'b0) begin errors++; $display("FAIL full_accept got err=%b cs_n=%b want 0/0", bus.start_err, bus.cs_n); end
        wait_done(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_done_timeout got 0 want 1"); end
        tick(); tick();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (xfer_cnt - x0 != 16) begin errors++; $display("FAIL full_byte_count got %0d want 16", xfer_cnt - x0); end
        checks++; if (cs_hi_cnt != c0) begin errors++; $display("FAIL full_cs_gap got %0d want 0", cs_hi_cnt - c0); end
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = 4'(i);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL full_rx[%0d] got %h want %h", i, bus.rd_data, e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_short_load_err();
        test_zero_count();
        test_start_during_burst();
        test_reset_mid_burst();
        test_full_16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
